// File: rtl/cmd_frame_tx_pkg.sv
// Shared constants for the command frame transmitter: opcodes, request
// type encodings, per-type frame lengths and the FSM state type.
// Optional inter-byte gap controlled by macro CMD_FRAME_GAP_EN.
package cmd_frame_tx_pkg;

  localparam logic [7:0] CMD_DATA   = 8'hA0;
  localparam logic [7:0] CMD_CTRL   = 8'hA1;
  localparam logic [7:0] CMD_FREQ   = 8'hA2;
  localparam logic [7:0] CMD_PERIOD = 8'hA3;
  localparam logic [7:0] CMD_REPEAT = 8'hA4;
  localparam logic [7:0] CMD_GLOBAL = 8'hA5;

  typedef enum logic [2:0] {
    REQ_DATA   = 3'd0,
    REQ_CTRL   = 3'd1,
    REQ_FREQ   = 3'd2,
    REQ_PERIOD = 3'd3,
    REQ_REPEAT = 3'd4,
    REQ_GLOBAL = 3'd5
  } req_type_e;

  localparam logic [2:0] LEN_DATA   = 3'd7;
  localparam logic [2:0] LEN_CTRL   = 3'd3;
  localparam logic [2:0] LEN_FREQ   = 3'd6;
  localparam logic [2:0] LEN_PERIOD = 3'd3;
  localparam logic [2:0] LEN_REPEAT = 3'd3;
  localparam logic [2:0] LEN_GLOBAL = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
`ifdef CMD_FRAME_GAP_EN
    ST_WAIT,
    ST_GAP
`else
    ST_WAIT
`endif
  } state_e;

  function automatic logic type_legal(input logic [2:0] t);
    return (t <= 3'd5);
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] t);
    logic [2:0] len;
    case (t)
      REQ_DATA:   len = LEN_DATA;
      REQ_CTRL:   len = LEN_CTRL;
      REQ_FREQ:   len = LEN_FREQ;
      REQ_PERIOD: len = LEN_PERIOD;
      REQ_REPEAT: len = LEN_REPEAT;
      REQ_GLOBAL: len = LEN_GLOBAL;
      default:    len = 3'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Request and UART-side signal bundle of the command frame transmitter.
// slave = transmitter side, master = requester/UART side.
interface cmd_frame_tx_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_type_i;
  logic [7:0]  req_channel_i;
  logic [7:0]  req_arg0_i;
  logic [7:0]  req_arg1_i;
  logic [31:0] req_payload_i;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_tick_i;
  logic        busy_o;
  logic        frame_done_tick_o;
  logic        err_tick_o;

  modport slave (
    input  req_valid_i, req_type_i, req_channel_i, req_arg0_i, req_arg1_i,
           req_payload_i, tx_done_tick_i,
    output req_ready_o, tx_start_o, tx_data_o, busy_o, frame_done_tick_o,
           err_tick_o
  );

  modport master (
    output req_valid_i, req_type_i, req_channel_i, req_arg0_i, req_arg1_i,
           req_payload_i, tx_done_tick_i,
    input  req_ready_o, tx_start_o, tx_data_o, busy_o, frame_done_tick_o,
           err_tick_o
  );
endinterface

// File: rtl/cmd_frame_tx_mux.sv
// Combinational frame byte select: picks the byte at index idx_i of the
// frame described by the latched request fields.
module cmd_frame_mux
  import cmd_frame_tx_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [2:0]  idx_i,
  input  logic [7:0]  channel_i,
  input  logic [7:0]  arg0_i,
  input  logic [7:0]  arg1_i,
  input  logic [31:0] payload_i,
  output logic [7:0]  byte_o
);

  // Byte lookup by frame type and byte index
  always_comb begin
    byte_o = '0;
    case (type_i)
      REQ_DATA: begin
        case (idx_i)
          3'd0:    byte_o = CMD_DATA;
          3'd1:    byte_o = channel_i;
          3'd2:    byte_o = arg0_i;
          3'd3:    byte_o = payload_i[7:0];
          3'd4:    byte_o = payload_i[15:8];
          3'd5:    byte_o = payload_i[23:16];
          3'd6:    byte_o = payload_i[31:24];
          default: byte_o = '0;
        endcase
      end
      REQ_CTRL: begin
        case (idx_i)
          3'd0:    byte_o = CMD_CTRL;
          3'd1:    byte_o = channel_i;
          3'd2:    byte_o = arg0_i;
          default: byte_o = '0;
        endcase
      end
      REQ_FREQ: begin
        case (idx_i)
          3'd0:    byte_o = CMD_FREQ;
          3'd1:    byte_o = arg0_i;
          3'd2:    byte_o = payload_i[7:0];
          3'd3:    byte_o = payload_i[15:8];
          3'd4:    byte_o = payload_i[23:16];
          3'd5:    byte_o = payload_i[31:24];
          default: byte_o = '0;
        endcase
      end
      REQ_PERIOD: begin
        case (idx_i)
          3'd0:    byte_o = CMD_PERIOD;
          3'd1:    byte_o = arg0_i;
          3'd2:    byte_o = arg1_i;
          default: byte_o = '0;
        endcase
      end
      REQ_REPEAT: begin
        case (idx_i)
          3'd0:    byte_o = CMD_REPEAT;
          3'd1:    byte_o = channel_i;
          3'd2:    byte_o = arg0_i;
          default: byte_o = '0;
        endcase
      end
      REQ_GLOBAL: begin
        case (idx_i)
          3'd0:    byte_o = CMD_GLOBAL;
          3'd1:    byte_o = {7'h0, arg0_i[0]};
          default: byte_o = '0;
        endcase
      end
      default: byte_o = '0;
    endcase
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Command frame transmitter: accepts one request, serialises its frame
// byte by byte to a UART transmitter via tx_start_o/tx_done_tick_i.
// Macro CMD_FRAME_GAP_EN inserts GAP_CYCLES idle cycles between bytes.
module cmd_frame_tx
  import cmd_frame_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  cmd_frame_tx_if.slave bus
);

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  type_q, type_d;
  logic [7:0]  chan_q, chan_d;
  logic [7:0]  arg0_q, arg0_d;
  logic [7:0]  arg1_q, arg1_d;
  logic [31:0] pay_q, pay_d;
  logic        fdone_q, fdone_d;
  logic        err_q, err_d;
  logic        accept;
  logic [2:0]  last_idx;
  logic [7:0]  mux_byte;

`ifdef CMD_FRAME_GAP_EN
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] gap_q, gap_d;
`else
  logic unused_gap_cfg;
  assign unused_gap_cfg = (GAP_CYCLES != 0);
`endif

  assign accept   = bus.req_valid_i && (state_q == ST_IDLE);
  assign last_idx = frame_len(type_q) - 3'd1;

  cmd_frame_mux u_mux (
    .type_i    (type_q),
    .idx_i     (idx_q),
    .channel_i (chan_q),
    .arg0_i    (arg0_q),
    .arg1_i    (arg1_q),
    .payload_i (pay_q),
    .byte_o    (mux_byte)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      type_q  <= '0;
      chan_q  <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      pay_q   <= '0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef CMD_FRAME_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      chan_q  <= chan_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      pay_q   <= pay_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
`ifdef CMD_FRAME_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  // Next-state, byte index and request latching
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    type_d  = type_q;
    chan_d  = chan_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    pay_d   = pay_q;
    fdone_d = 1'b0;
    err_d   = 1'b0;
`ifdef CMD_FRAME_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (type_legal(bus.req_type_i)) begin
            type_d  = bus.req_type_i;
            chan_d  = bus.req_channel_i;
            arg0_d  = bus.req_arg0_i;
            arg1_d  = bus.req_arg1_i;
            pay_d   = bus.req_payload_i;
            idx_d   = '0;
            state_d = ST_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_done_tick_i) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == last_idx) begin
            state_d = ST_IDLE;
            fdone_d = 1'b1;
          end else begin
`ifdef CMD_FRAME_GAP_EN
            if (GAP_CYCLES == 0) begin
              state_d = ST_START;
            end else begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_CYCLES - 1);
            end
`else
            state_d = ST_START;
`endif
          end
        end
      end
`ifdef CMD_FRAME_GAP_EN
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_START;
        else             gap_d   = gap_q - 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready_o       = (state_q == ST_IDLE);
  assign bus.tx_start_o        = (state_q == ST_START);
  assign bus.tx_data_o         = ((state_q == ST_START) || (state_q == ST_WAIT)) ? mux_byte : '0;
  assign bus.busy_o            = (state_q != ST_IDLE);
  assign bus.frame_done_tick_o = fdone_q;
  assign bus.err_tick_o        = err_q;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx with a byte scoreboard and a simple
// UART model that answers each tx_start_o with a tx_done_tick_i.
module tb_cmd_frame_tx;
  import cmd_frame_tx_pkg::*;

  localparam int unsigned GAP = 16;
`ifdef CMD_FRAME_GAP_EN
  localparam int EXP_DELTA = GAP + 1;
`else
  localparam int EXP_DELTA = 1;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  cmd_frame_tx_if bus ();

  cmd_frame_tx #(.GAP_CYCLES(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int start_cnt = 0, done_cnt = 0, fdone_cnt = 0, err_cnt = 0;
  int ncnt = 0, done_n = 0, pend = 0;
  int stray_req = 0, stray_ack = 0;
  bit have_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [2:0] t, input logic [7:0] ch,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [31:0] pl);
    case (t)
      3'd0: begin
        exp_q.push_back(CMD_DATA); exp_q.push_back(ch); exp_q.push_back(a0);
        exp_q.push_back(pl[7:0]); exp_q.push_back(pl[15:8]);
        exp_q.push_back(pl[23:16]); exp_q.push_back(pl[31:24]);
      end
      3'd1: begin exp_q.push_back(CMD_CTRL); exp_q.push_back(ch); exp_q.push_back(a0); end
      3'd2: begin
        exp_q.push_back(CMD_FREQ); exp_q.push_back(a0);
        exp_q.push_back(pl[7:0]); exp_q.push_back(pl[15:8]);
        exp_q.push_back(pl[23:16]); exp_q.push_back(pl[31:24]);
      end
      3'd3: begin exp_q.push_back(CMD_PERIOD); exp_q.push_back(a0); exp_q.push_back(a1); end
      3'd4: begin exp_q.push_back(CMD_REPEAT); exp_q.push_back(ch); exp_q.push_back(a0); end
      3'd5: begin exp_q.push_back(CMD_GLOBAL); exp_q.push_back({7'h0, a0[0]}); end
      default: ;
    endcase
  endtask

  // Monitor and UART model share one negedge process to keep ordering fixed
  initial begin
    bus.tx_done_tick_i = 1'b0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (rst_i) begin
        pend = 0;
        have_done = 1'b0;
        bus.tx_done_tick_i = 1'b0;
      end else begin
        if (bus.tx_start_o) begin
          start_cnt++;
          check("ready_low_in_frame", bus.req_ready_o, 1'b0);
          check("busy_in_frame", bus.busy_o, 1'b1);
          check("sb_has_byte", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("tx_byte", bus.tx_data_o, exp_q.pop_front());
          if (have_done) check("done_to_start", ncnt - done_n, EXP_DELTA);
          have_done = 1'b0;
        end
        if (bus.frame_done_tick_o) begin
          fdone_cnt++;
          have_done = 1'b0;
          check("ready_at_frame_done", bus.req_ready_o, 1'b1);
        end
        if (bus.err_tick_o) err_cnt++;
        bus.tx_done_tick_i = 1'b0;
        if (stray_req != stray_ack) begin
          stray_ack++;
          bus.tx_done_tick_i = 1'b1;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.tx_done_tick_i = 1'b1;
            done_cnt++;
            done_n = ncnt;
            have_done = 1'b1;
          end
        end
        if (bus.tx_start_o) pend = 3;
      end
    end
  end

  task automatic send_req(input logic [2:0] t, input logic [7:0] ch,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [31:0] pl);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.req_ready_o && g < 500) begin @(negedge clk); g++; end
    check("ready_before_req", bus.req_ready_o, 1'b1);
    if (t <= 3'd5) push_frame(t, ch, a0, a1, pl);
    bus.req_type_i    = t;
    bus.req_channel_i = ch;
    bus.req_arg0_i    = a0;
    bus.req_arg1_i    = a1;
    bus.req_payload_i = pl;
    bus.req_valid_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    check("start_after_accept", bus.tx_start_o, (t <= 3'd5));
    if (t > 3'd5) check("err_tick_next", bus.err_tick_o, 1'b1);
  endtask

  task automatic wait_frame(input string tag);
    int base, g;
    base = fdone_cnt;
    g = 0;
    while (fdone_cnt == base && g < 1000) begin @(posedge clk); g++; end
    repeat (3) @(posedge clk);
    check({tag, "_one_frame_done"}, fdone_cnt - base, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, bus.busy_o, 1'b0);
  endtask

  initial begin
    int bs, be, bf, bd, g;
    bus.req_valid_i   = 1'b0;
    bus.req_type_i    = '0;
    bus.req_channel_i = '0;
    bus.req_arg0_i    = '0;
    bus.req_arg1_i    = '0;
    bus.req_payload_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready_o, 1'b1);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_start", bus.tx_start_o, 1'b0);
    check("rst_data", bus.tx_data_o, 8'h00);
    check("rst_fdone", bus.frame_done_tick_o, 1'b0);
    check("rst_err", bus.err_tick_o, 1'b0);
    rst_i = 1'b0;

    send_req(3'd3, 8'h00, 8'h14, 8'h05, 32'h0);
    wait_frame("period");
    send_req(3'd2, 8'h00, 8'h04, 8'h00, 32'h1234_5678);
    wait_frame("freq");
    send_req(3'd0, 8'h03, 8'h04, 8'h00, 32'h5555_5555);
    wait_frame("data");
    send_req(3'd1, 8'h03, 8'h03, 8'h00, 32'h0);
    wait_frame("ctrl");

    bs = start_cnt; be = err_cnt;
    send_req(3'd7, 8'h11, 8'h22, 8'h33, 32'hDEAD_BEEF);
    repeat (10) @(posedge clk);
    check("illegal_err_once", err_cnt - be, 1);
    check("illegal_no_start", start_cnt - bs, 0);
    check("illegal_idle", bus.busy_o, 1'b0);

    bs = start_cnt; bf = fdone_cnt;
    stray_req++;
    repeat (6) @(posedge clk);
    check("stray_done_no_start", start_cnt - bs, 0);
    check("stray_done_no_fdone", fdone_cnt - bf, 0);
    check("stray_done_idle", bus.busy_o, 1'b0);

    send_req(3'd4, 8'h0F, 8'h03, 8'h00, 32'h0);
    wait_frame("repeat");

    bf = fdone_cnt; bd = done_cnt;
    send_req(3'd0, 8'h07, 8'h09, 8'h00, 32'hCAFE_F00D);
    g = 0;
    while (done_cnt < bd + 2 && g < 1000) begin @(posedge clk); g++; end
    check("abort_two_bytes_done", done_cnt - bd, 2);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_start", bus.tx_start_o, 1'b0);
    check("abort_data", bus.tx_data_o, 8'h00);
    check("abort_ready", bus.req_ready_o, 1'b1);
    check("abort_fdone", bus.frame_done_tick_o, 1'b0);
    check("abort_err", bus.err_tick_o, 1'b0);
    rst_i = 1'b0;
    exp_q.delete();
    repeat (30) @(posedge clk);
    check("abort_no_frame_done", fdone_cnt - bf, 0);

    send_req(3'd5, 8'h00, 8'h01, 8'h00, 32'h0);
    wait_frame("global");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
